// File: rtl/qspi_bridge_seq.sv
// qspi_bridge_seq: sequences QSPI command/address/dummy/data phases into
// pipelined Wishbone reads (prefetched into a readback FIFO) and burst writes.
// Command codes: 8'h02 WRITE_THRU, 8'h03 READ, 8'h0B FAST_READ, 8'h9A DET_VT.
// Optional: define QSPI_BRIDGE_STATUS_EN to enable the 8'h05 status read.
module qspi_bridge_seq #(
   parameter int unsigned         ADDRBITS     = 26,
   parameter int unsigned         DATABITS     = 16,
   parameter int unsigned         IOREG_BITS   = 32,
   parameter int unsigned         FIFO_DEPTH   = 16,
   parameter int unsigned         DUMMY_CYCLES = 20,
   parameter logic [DATABITS-1:0] ERR_FILL     = 16'hDEAD
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   output logic [7:0]            txnbc_o,
   output logic                  txndir_o,
   output logic [IOREG_BITS-1:0] txndata_o,
   input  logic [IOREG_BITS-1:0] txndata_i,
   input  logic                  txndone_i,
   input  logic                  txnreset_i,
   output logic                  vt_mode,
   output logic                  err_o,
   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   output logic                  wb_we_o,
   output logic [ADDRBITS-1:0]   wb_adr_o,
   output logic [DATABITS-1:0]   wb_dat_o,
   input  logic                  wb_err_i,
   input  logic                  wb_ack_i,
   input  logic                  wb_stall_i,
   input  logic [DATABITS-1:0]   wb_dat_i
);

   localparam logic [7:0] CMD_WRITE_THRU = 8'h02;
   localparam logic [7:0] CMD_READ       = 8'h03;
   localparam logic [7:0] CMD_FAST_READ  = 8'h0B;
   localparam logic [7:0] CMD_DET_VT     = 8'h9A;
`ifdef QSPI_BRIDGE_STATUS_EN
   localparam logic [7:0] CMD_STATUS     = 8'h05;
`endif

   localparam int unsigned ADDR_PH  = ((ADDRBITS + 7) / 8) * 8;
   localparam int unsigned DATA_PH  = ((DATABITS + 7) / 8) * 8;
   localparam logic [7:0]  BC_CMD   = 8'd8;
   localparam logic [7:0]  BC_ADDR  = 8'(ADDR_PH);
   localparam logic [7:0]  BC_STALL = 8'(4 * DUMMY_CYCLES);
   localparam logic [7:0]  BC_DATA  = 8'(DATA_PH);
   localparam int unsigned PW       = $clog2(FIFO_DEPTH);
   localparam int unsigned CW       = 7;
   localparam int unsigned SW       = CW + 1;

   typedef enum logic [2:0] {ST_CMD, ST_ADDR, ST_STALL, ST_READ, ST_WRITE} state_t;

   state_t              state, state_next;
   logic [2:0]          done_s, ce_s;
   logic                wstb_pe, ce_high, ce_rise;
   logic [7:0]          cmd;
   logic                rd_active, rd_active_next, rd_start, wr_req;
   logic                accept, resp, push, pop, stb_next, cyc_next;
   logic [CW-1:0]       inflight, inflight_next, drop_cnt;
   logic [CW-1:0]       level, level_next;
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [DATABITS-1:0] mem [FIFO_DEPTH];
   logic [DATABITS-1:0] last_wdata;
   logic                status_mode;
   logic                unused_txn;

   assign unused_txn = ^txndata_i;

   assign wstb_pe = done_s[1] & ~done_s[2];
   assign ce_high = ce_s[1];
   assign ce_rise = ce_s[1] & ~ce_s[2];

   // Two-flop synchronisers plus edge history for phase-done and CE
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         done_s <= '0;
         ce_s   <= '1;
      end else begin
         done_s <= {done_s[1:0], txndone_i};
         ce_s   <= {ce_s[1:0], txnreset_i};
      end
   end

   // Phase state register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state <= ST_CMD;
      else         state <= state_next;
   end

   // Next phase and the phase shape presented to the shifter
   always_comb begin
      state_next = state;
      txnbc_o    = '0;
      txndir_o   = 1'b0;
      if (ce_high) begin
         state_next = ST_CMD;
      end else begin
         case (state)
            ST_CMD:   txnbc_o = BC_CMD;
            ST_ADDR:  txnbc_o = BC_ADDR;
            ST_STALL: txnbc_o = BC_STALL;
            ST_READ:  begin txnbc_o = BC_DATA; txndir_o = 1'b1; end
            ST_WRITE: txnbc_o = BC_DATA;
            default:  txnbc_o = '0;
         endcase
         if (wstb_pe) begin
            case (state)
               ST_CMD: begin
`ifdef QSPI_BRIDGE_STATUS_EN
                  if (txndata_i[7:0] == CMD_STATUS) state_next = ST_READ; else
`endif
                  state_next = ST_ADDR;
               end
               ST_ADDR: begin
                  case (cmd)
                     CMD_READ:       state_next = ST_READ;
                     CMD_FAST_READ:  state_next = ST_STALL;
                     CMD_WRITE_THRU: state_next = ST_WRITE;
                     default:        state_next = ST_CMD;
                  endcase
               end
               ST_STALL: state_next = ST_READ;
               ST_READ:  state_next = ST_READ;
               ST_WRITE: state_next = ST_WRITE;
               default:  state_next = ST_CMD;
            endcase
         end
      end
   end

   // Bus handshake, FIFO occupancy and request throttling
   always_comb begin
      accept   = wb_stb_o & ~wb_stall_i;
      resp     = wb_ack_i | wb_err_i;
      rd_start = (state == ST_ADDR) && wstb_pe && !ce_high &&
                 ((cmd == CMD_READ) || (cmd == CMD_FAST_READ));
      wr_req   = (state == ST_WRITE) && wstb_pe && !ce_high;
      pop      = (state == ST_READ) && wstb_pe && !ce_high && !status_mode && (level != '0);
      push     = resp && (inflight != '0) && (drop_cnt == '0) && !ce_high && !wb_we_o &&
                 ((level != CW'(FIFO_DEPTH)) || pop);

      inflight_next = inflight;
      if (accept && !(resp && inflight != '0))      inflight_next = inflight + CW'(1);
      else if (!accept && resp && inflight != '0)   inflight_next = inflight - CW'(1);

      level_next = level;
      if (push && !pop)      level_next = level + CW'(1);
      else if (!push && pop) level_next = level - CW'(1);

      rd_active_next = ce_high ? 1'b0 : (rd_start | rd_active);

      // A stalled request stays up; a fresh read needs room for its data
      if (ce_high)                     stb_next = 1'b0;
      else if (wr_req)                 stb_next = 1'b1;
      else if (wb_stb_o && wb_stall_i) stb_next = 1'b1;
      else if (rd_active_next)         stb_next = ({1'b0, level_next} + {1'b0, inflight_next}) < SW'(FIFO_DEPTH);
      else                             stb_next = 1'b0;

      cyc_next = stb_next | (inflight_next != '0);
   end

   // Wishbone master registers, inflight tracking and late-response discard
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wb_cyc_o  <= 1'b0;
         wb_stb_o  <= 1'b0;
         wb_we_o   <= 1'b0;
         wb_adr_o  <= '0;
         wb_dat_o  <= '0;
         rd_active <= 1'b0;
         inflight  <= '0;
         drop_cnt  <= '0;
      end else begin
         wb_cyc_o  <= cyc_next;
         wb_stb_o  <= stb_next;
         rd_active <= rd_active_next;
         inflight  <= inflight_next;
         if (ce_high)                                        wb_we_o <= 1'b0;
         else if (state == ST_ADDR && wstb_pe)               wb_we_o <= (cmd == CMD_WRITE_THRU);
         if (state == ST_ADDR && wstb_pe && !ce_high)        wb_adr_o <= txndata_i[ADDRBITS-1:0];
         else if (accept)                                    wb_adr_o <= wb_adr_o + ADDRBITS'(1);
         if (wr_req)                                         wb_dat_o <= txndata_i[DATABITS-1:0];
         // everything outstanding when CE rises belongs to the aborted transfer
         if (ce_high)                                        drop_cnt <= inflight_next;
         else if (resp && drop_cnt != '0)                    drop_cnt <= drop_cnt - CW'(1);
      end
   end

   // Command latch, VT override and sticky error flag
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cmd        <= '0;
         last_wdata <= '0;
         vt_mode    <= 1'b0;
         err_o      <= 1'b0;
      end else begin
         if (ce_rise) begin
            cmd        <= '0;
            last_wdata <= '0;
            if (cmd == CMD_DET_VT) vt_mode <= 1'b1;
            else if (cmd == CMD_WRITE_THRU && last_wdata == DATABITS'(16'h00F0)) vt_mode <= 1'b0;
         end else if (state == ST_CMD && wstb_pe && !ce_high) begin
            cmd <= txndata_i[7:0];
         end
         if (wr_req) last_wdata <= txndata_i[DATABITS-1:0];
         if (wb_err_i) err_o <= 1'b1;
`ifdef QSPI_BRIDGE_STATUS_EN
         else if (ce_rise && status_mode) err_o <= 1'b0;
`endif
      end
   end

`ifdef QSPI_BRIDGE_STATUS_EN
   // Status-read marker, held until CE rises
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)                                 status_mode <= 1'b0;
      else if (ce_high)                            status_mode <= 1'b0;
      else if (state == ST_CMD && wstb_pe && txndata_i[7:0] == CMD_STATUS) status_mode <= 1'b1;
   end
`else
   assign status_mode = 1'b0;
`endif

   // Readback FIFO pointers and level; CE high flushes
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (ce_high) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         level <= level_next;
      end
   end

   // Readback FIFO storage; bus errors store the fill pattern
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= wb_err_i ? ERR_FILL : wb_dat_i;
   end

   // Word offered to the shifter during read data phases
   always_comb begin
      txndata_o = '0;
      if (state == ST_READ && !ce_high) begin
         if (status_mode)        txndata_o = IOREG_BITS'({err_o, vt_mode, level});
         else if (level != '0)   txndata_o = IOREG_BITS'(mem[rd_ptr]);
      end
   end

endmodule
